// File: rtl/rom_fetch_buffer.sv
// rom_fetch_buffer: fully-associative word buffer between the CPU fetch port and the SPI ROM reader.
// Latency: hit -> rsp_valid 1 cycle after accept; miss -> rsp_valid 1 cycle after rom_data_valid rises.
// Backpressure: one fetch in flight (req_ready low outside IDLE), rsp held until rsp_ready, rom_addr held until rom_addr_ready.
//
// Ports: clk/rstn (sync, active-low); req_* CPU fetch request (byte address, bits [1:0] ignored);
//        rsp_* fetched word to CPU; flush invalidates all entries; rom_addr* request to the ROM reader;
//        rom_data/rom_data_valid word returned by the ROM reader (valid may stay high several cycles).
// Optional feature macro: ROM_FETCH_PREFETCH_EN -- after a miss response, prefetch the next word if not buffered.
module rom_fetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_valid,
    output logic              req_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    input  logic              flush,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_addr_valid,
    input  logic              rom_addr_ready,
    input  logic [31:0]       rom_data,
    input  logic              rom_data_valid
);
    localparam int TAG_W = ADDR_W - 2;
    localparam int PTR_W = $clog2(DEPTH);

`ifdef ROM_FETCH_PREFETCH_EN
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_PF_ISSUE, S_PF_WAIT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
`endif

    state_t            state_q, state_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [TAG_W-1:0]  tag_d  [DEPTH];
    logic [31:0]       data_q [DEPTH];
    logic [31:0]       data_d [DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [TAG_W-1:0]  cur_tag_q, cur_tag_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_addr_valid_q, rom_addr_valid_d;
    logic              flush_pending_q, flush_pending_d;
    logic              rom_dv_q, rom_dv_d;

    logic [TAG_W-1:0]  req_tag;
    logic              lookup_hit;
    logic [31:0]       lookup_data;
    logic              rom_edge;
    logic              fill_en;
    logic [TAG_W-1:0]  fill_tag;
    logic              unused_addr_bits;

`ifdef ROM_FETCH_PREFETCH_EN
    logic              miss_q, miss_d;
    logic [TAG_W-1:0]  pf_tag;
    logic              pf_hit;
    assign pf_tag = cur_tag_q + TAG_W'(1);
`endif

    assign req_tag          = req_addr[ADDR_W-1:2];
    assign unused_addr_bits = ^req_addr[1:0];
    // Only a 0->1 transition counts, so a level left high by an earlier read is not taken as new data.
    assign rom_edge         = rom_data_valid && !rom_dv_q;
    assign rom_dv_d         = rom_data_valid;

    assign req_ready      = rstn && (state_q == S_IDLE) && !flush_pending_q && !flush;
    assign rsp_data       = rsp_data_q;
    assign rsp_valid      = rsp_valid_q;
    assign rom_addr       = rom_addr_q;
    assign rom_addr_valid = rom_addr_valid_q;

    // Parallel tag compare; fills only follow a miss on the same tag, so at most one entry matches.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
`ifdef ROM_FETCH_PREFETCH_EN
        pf_hit      = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == req_tag)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[i];
            end
`ifdef ROM_FETCH_PREFETCH_EN
            if (valid_q[i] && (tag_q[i] == pf_tag)) begin
                pf_hit = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        state_d          = state_q;
        valid_d          = valid_q;
        tag_d            = tag_q;
        data_d           = data_q;
        ptr_d            = ptr_q;
        cur_tag_d        = cur_tag_q;
        rsp_data_d       = rsp_data_q;
        rsp_valid_d      = rsp_valid_q;
        rom_addr_d       = rom_addr_q;
        rom_addr_valid_d = rom_addr_valid_q;
        flush_pending_d  = flush_pending_q;
        fill_en          = 1'b0;
        fill_tag         = cur_tag_q;
`ifdef ROM_FETCH_PREFETCH_EN
        miss_d           = miss_q;
`endif

        // A flush during a transaction is remembered and applied once back in IDLE.
        if (flush && (state_q != S_IDLE)) begin
            flush_pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (flush || flush_pending_q) begin
                    valid_d         = '0;
                    ptr_d           = '0;
                    flush_pending_d = 1'b0;
                end else if (req_valid && req_ready) begin
                    cur_tag_d = req_tag;
                    if (lookup_hit) begin
                        rsp_data_d  = lookup_data;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
`ifdef ROM_FETCH_PREFETCH_EN
                        miss_d      = 1'b0;
`endif
                    end else begin
                        rom_addr_d       = {req_tag, 2'b00};
                        rom_addr_valid_d = 1'b1;
                        state_d          = S_ISSUE;
`ifdef ROM_FETCH_PREFETCH_EN
                        miss_d           = 1'b1;
`endif
                    end
                end
            end
            S_ISSUE: begin
                if (rom_addr_ready) begin
                    rom_addr_valid_d = 1'b0;
                    state_d          = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rom_edge) begin
                    fill_en     = 1'b1;
                    rsp_data_d  = rom_data;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
`ifdef ROM_FETCH_PREFETCH_EN
                    // A pending flush would discard the prefetched word anyway, so skip it.
                    if (miss_q && !pf_hit && !flush_pending_q && !flush) begin
                        rom_addr_d       = {pf_tag, 2'b00};
                        rom_addr_valid_d = 1'b1;
                        state_d          = S_PF_ISSUE;
                    end
`endif
                end
            end
`ifdef ROM_FETCH_PREFETCH_EN
            S_PF_ISSUE: begin
                if (rom_addr_ready) begin
                    rom_addr_valid_d = 1'b0;
                    state_d          = S_PF_WAIT;
                end
            end
            S_PF_WAIT: begin
                if (rom_edge) begin
                    fill_en  = !(flush_pending_q || flush);
                    fill_tag = pf_tag;
                    state_d  = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Round-robin fill, independent of which entries are currently valid.
        if (fill_en) begin
            valid_d[ptr_q] = 1'b1;
            tag_d[ptr_q]   = fill_tag;
            data_d[ptr_q]  = rom_data;
            ptr_d          = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q          <= S_IDLE;
            valid_q          <= '0;
            ptr_q            <= '0;
            cur_tag_q        <= '0;
            rsp_data_q       <= '0;
            rsp_valid_q      <= 1'b0;
            rom_addr_q       <= '0;
            rom_addr_valid_q <= 1'b0;
            flush_pending_q  <= 1'b0;
            rom_dv_q         <= 1'b0;
`ifdef ROM_FETCH_PREFETCH_EN
            miss_q           <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            valid_q          <= valid_d;
            ptr_q            <= ptr_d;
            cur_tag_q        <= cur_tag_d;
            rsp_data_q       <= rsp_data_d;
            rsp_valid_q      <= rsp_valid_d;
            rom_addr_q       <= rom_addr_d;
            rom_addr_valid_q <= rom_addr_valid_d;
            flush_pending_q  <= flush_pending_d;
            rom_dv_q         <= rom_dv_d;
`ifdef ROM_FETCH_PREFETCH_EN
            miss_q           <= miss_d;
`endif
        end
    end

    // Tag/data storage needs no reset: valid_q gates every use.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_rom_fetch_buffer.sv
module tb_rom_fetch_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 24;

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] req_addr;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   rsp_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          flush;
    logic [AW-1:0] rom_addr;
    logic          rom_addr_valid;
    logic          rom_addr_ready;
    logic [31:0]   rom_data;
    logic          rom_data_valid;

    always #5 clk = ~clk;

    rom_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rstn(rstn),
        .req_addr(req_addr), .req_valid(req_valid), .req_ready(req_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .flush(flush),
        .rom_addr(rom_addr), .rom_addr_valid(rom_addr_valid), .rom_addr_ready(rom_addr_ready),
        .rom_data(rom_data), .rom_data_valid(rom_data_valid)
    );

    int total = 0;
    int bad   = 0;
    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // ROM reader model knobs and observation
    int            rdy_wait = 0;
    int            data_lat = 1;
    int            dv_hold  = 1;
    bit            rom_busy = 1'b0;
    int            dv_rise_cycle = 0;
    logic [AW-1:0] rom_log [$];
    logic [AW-1:0] rom_a;

    // Reference buffer: list of words with round-robin slot pointer.
    bit          m_valid [DEPTH];
    logic [21:0] m_word  [DEPTH];
    int          m_ptr = 0;

    function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
        logic [21:0] w;
        w = a[AW-1:2];
        if (w == 22'h40) return 32'h01234567;
        return {w[9:0], w} ^ 32'hA5C3_0F1E;
    endfunction

    function automatic bit model_has(input logic [21:0] w);
        for (int i = 0; i < DEPTH; i++)
            if (m_valid[i] && m_word[i] == w) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_fill(input logic [21:0] w);
        m_valid[m_ptr] = 1'b1;
        m_word[m_ptr]  = w;
        m_ptr = (m_ptr + 1) % DEPTH;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        total++;
        bad++;
        $display("FAIL %s: actual=timeout required=event", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ROM reader: accepts after rdy_wait cycles, returns data after data_lat, holds valid dv_hold cycles.
    initial begin
        rom_addr_ready = 1'b0;
        rom_data_valid = 1'b0;
        rom_data       = '0;
        forever begin
            step();
            if (rstn === 1'b1 && rom_addr_valid === 1'b1) begin
                rom_busy = 1'b1;
                rom_a    = rom_addr;
                for (int k = 0; k < rdy_wait; k++) step();
                rom_addr_ready = 1'b1;
                step();
                rom_addr_ready = 1'b0;
                rom_log.push_back(rom_a);
                for (int k = 0; k < data_lat; k++) step();
                rom_data       = rom_word(rom_a);
                rom_data_valid = 1'b1;
                dv_rise_cycle  = cycle_cnt;
                for (int k = 0; k < dv_hold; k++) step();
                rom_data_valid = 1'b0;
                rom_busy       = 1'b0;
            end
        end
    end

    task automatic wait_idle(input string name, output bit ok);
        int n;
        n = 0;
        while ((!req_ready || rom_busy) && n < 1000) begin step(); n++; end
        ok = (n < 1000);
        if (!ok) tmo({name, " idle"});
    endtask

    task automatic idle_flush(input string name);
        bit ok;
        wait_idle(name, ok);
        if (!ok) return;
        req_addr  = 24'h000100;
        req_valid = 1'b1;
        flush     = 1'b1;
        #1;
        chk({name, " flush blocks req_ready"}, 32'(req_ready), 0);
        step();
        flush     = 1'b0;
        req_valid = 1'b0;
        model_clear();
    endtask

    task automatic fetch(input string name, input logic [AW-1:0] addr, input bit exp_hit,
                         input int rw, input int dl, input int dh, input int stall, input bit flush_mid);
        bit          ok;
        bit          flushed;
        int          n;
        int          iss;
        int          lsz;
        logic [31:0] exp_d;
        logic [21:0] w;
        exp_d = rom_word(addr);
        w     = addr[AW-1:2];
        wait_idle(name, ok);
        if (!ok) return;
        rdy_wait  = rw;
        data_lat  = dl;
        dv_hold   = dh;
        req_addr  = addr;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        req_addr  = AW'($urandom);
        lsz       = rom_log.size();
        if (exp_hit) begin
            chk({name, " hit rsp_valid"}, 32'(rsp_valid), 1);
            chk({name, " hit rsp_data"}, rsp_data, exp_d);
            chk({name, " hit no rom req"}, 32'(rom_addr_valid), 0);
            if (flush_mid) flush = 1'b1;
        end else begin
            chk({name, " miss rom_addr_valid"}, 32'(rom_addr_valid), 1);
            chk({name, " miss rom_addr"}, 32'(rom_addr), 32'({w, 2'b00}));
            chk({name, " miss no early rsp"}, 32'(rsp_valid), 0);
            iss = 0;
            flushed = 1'b0;
            n = 0;
            while (!rsp_valid && n < 2000) begin
                if (rom_addr_valid) begin
                    iss++;
                    if (rom_addr !== {w, 2'b00}) chk({name, " rom_addr stable"}, 32'(rom_addr), 32'({w, 2'b00}));
                end else if (flush_mid && !flushed) begin
                    flush   = 1'b1;
                    flushed = 1'b1;
                end
                step();
                flush = 1'b0;
                n++;
            end
            if (n >= 2000) begin tmo({name, " miss rsp"}); return; end
            chk({name, " issue hold cycles"}, iss, rw + 1);
            chk({name, " miss latency"}, cycle_cnt, dv_rise_cycle + 1);
            chk({name, " miss rsp_data"}, rsp_data, exp_d);
            chk({name, " one rom read"}, rom_log.size(), lsz + 1);
        end
        for (int s = 0; s < stall; s++) begin
            step();
            flush = 1'b0;
            chk({name, " stall rsp_valid"}, 32'(rsp_valid), 1);
            chk({name, " stall rsp_data"}, rsp_data, exp_d);
            chk({name, " stall req_ready"}, 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        flush     = 1'b0;
        chk({name, " rsp dropped"}, 32'(rsp_valid), 0);
        if (!exp_hit) begin
            model_fill(w);
`ifdef ROM_FETCH_PREFETCH_EN
            if (!flush_mid && !model_has(w + 22'd1)) model_fill(w + 22'd1);
`endif
        end
        if (flush_mid) model_clear();
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        bit            pre_flush;
        bit            exp_hit;
        int            rw;
        int            stall;
        bit            flush_mid;
    } vec_t;

    initial begin
        vec_t          tbl [$];
        logic [21:0]   pool [10];
        logic [AW-1:0] a;
        bit            ok;
        bit            hit;
        int            n;
        int            rsp_seen;

        rstn = 1'b0; req_addr = '0; req_valid = 1'b0; rsp_ready = 1'b0; flush = 1'b0;
        model_clear();

`ifdef ROM_FETCH_PREFETCH_EN
        tbl.push_back('{24'h000100, 0, 0, 0, 0, 0});
        tbl.push_back('{24'h000102, 0, 1, 0, 0, 0});
        tbl.push_back('{24'h000104, 0, 1, 0, 1, 0});
        tbl.push_back('{24'h000200, 1, 0, 1, 0, 1});
        tbl.push_back('{24'h000204, 0, 0, 0, 0, 0});
        tbl.push_back('{24'h000200, 0, 0, 2, 0, 0});
        tbl.push_back('{24'h000208, 0, 1, 0, 0, 0});
`else
        tbl.push_back('{24'h000100, 0, 0, 0, 0, 0});
        tbl.push_back('{24'h000102, 0, 1, 0, 0, 0});
        tbl.push_back('{24'h000010, 1, 0, 0, 0, 0});
        tbl.push_back('{24'h000020, 0, 0, 1, 0, 0});
        tbl.push_back('{24'h000030, 0, 0, 0, 1, 0});
        tbl.push_back('{24'h000040, 0, 0, 2, 0, 0});
        tbl.push_back('{24'h000050, 0, 0, 0, 0, 0});
        tbl.push_back('{24'h000020, 0, 1, 0, 0, 0});
        tbl.push_back('{24'h000010, 0, 0, 10, 0, 0});
        tbl.push_back('{24'h000020, 0, 0, 0, 5, 0});
        tbl.push_back('{24'h000040, 0, 1, 0, 0, 0});
        tbl.push_back('{24'h000050, 0, 1, 0, 2, 0});
        tbl.push_back('{24'h000200, 0, 0, 1, 0, 1});
        tbl.push_back('{24'h000200, 0, 0, 0, 0, 0});
        tbl.push_back('{24'h000050, 0, 0, 0, 0, 0});
        tbl.push_back('{24'hFFFFFC, 0, 0, 0, 0, 0});
        tbl.push_back('{24'hFFFFFF, 0, 1, 0, 0, 0});
`endif

        // Reset values
        for (int i = 0; i < 3; i++) step();
        chk("reset req_ready", 32'(req_ready), 0);
        chk("reset rsp_valid", 32'(rsp_valid), 0);
        chk("reset rsp_data", rsp_data, 0);
        chk("reset rom_addr_valid", 32'(rom_addr_valid), 0);
        chk("reset rom_addr", 32'(rom_addr), 0);
        rstn = 1'b1;
        step();
        chk("post-reset req_ready", 32'(req_ready), 1);

        foreach (tbl[i]) begin
            if (tbl[i].pre_flush) idle_flush($sformatf("vec%0d", i));
            fetch($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp_hit, tbl[i].rw, 2, 1,
                  tbl[i].stall, tbl[i].flush_mid);
        end

`ifdef ROM_FETCH_PREFETCH_EN
        // Prefetch wraps past the top of the address space.
        idle_flush("pfwrap");
        fetch("pfwrap miss", 24'hFFFFFC, 1'b0, 0, 2, 1, 0, 1'b0);
        wait_idle("pfwrap", ok);
        chk("pfwrap rom reads", rom_log.size() >= 2 ? 32'(rom_log[rom_log.size()-1]) : 32'hDEAD, 32'h000000);
        fetch("pfwrap hit", 24'h000000, 1'b1, 0, 2, 1, 0, 1'b0);
`endif

        // Reset during WAIT; the late data edge must not produce a response.
        wait_idle("rst_abort", ok);
        rdy_wait = 0; data_lat = 6; dv_hold = 2;
        req_addr = 24'h000300; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n = 0;
        while (rom_addr_valid && n < 100) begin step(); n++; end
        rstn = 1'b0;
        step();
        chk("abort req_ready", 32'(req_ready), 0);
        chk("abort rom_addr_valid", 32'(rom_addr_valid), 0);
        chk("abort rom_addr", 32'(rom_addr), 0);
        rstn = 1'b1;
        model_clear();
        rsp_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (rsp_valid) rsp_seen++;
        end
        chk("abort no response", rsp_seen, 0);
        fetch("after abort", 24'h000102, 1'b0, 0, 1, 1, 0, 1'b0);

        // Randomized traffic against the reference buffer
        for (int i = 0; i < 10; i++) pool[i] = 22'(i * 3);
        pool[8] = 22'h3FFFFF;
        pool[9] = 22'h3FFFFE;
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 19) == 0) idle_flush($sformatf("rnd%0d", t));
            a   = {pool[$urandom_range(0, 9)], 2'($urandom)};
            hit = model_has(a[AW-1:2]);
            fetch($sformatf("rnd%0d", t), a, hit, $urandom_range(0, 3), $urandom_range(1, 4),
                  $urandom_range(1, 3), $urandom_range(0, 2), $urandom_range(0, 14) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end
endmodule

// File: doc/rom_fetch_buffer.md
Name: rom_fetch_buffer

Overview:
- Small fully-associative word buffer between the CPU instruction-fetch port and the SPI ROM reader.
- Hits return in one cycle.
- Misses issue one 24-bit read to the SPI ROM reader, wait for its 32-bit word, fill an entry (round-robin replacement) and return the word.
- The ROM reader is slow (about 64 SPI half-cycles per word), so this block exists to avoid re-reading loop bodies.

Parameters:
- DEPTH, 4, number of buffered words; power of two, 2..16.
- ADDR_W, 24, byte-address width; matches the ROM reader address.

Ports:
- clk  input  1  system clock
- rstn  input  1  reset, synchronous, active-low
- req_addr  input  ADDR_W  CPU fetch byte address; bits [1:0] ignored (word-aligned)
- req_valid  input  1  CPU fetch request
- req_ready  output  1  block can accept a request
- rsp_data  output  32  fetched word
- rsp_valid  output  1  rsp_data valid
- rsp_ready  input  1  CPU accepts response
- flush  input  1  invalidate all entries
- rom_addr  output  ADDR_W  address to ROM reader
- rom_addr_valid  output  1  ROM read request
- rom_addr_ready  input  1  ROM reader idle
- rom_data  input  32  ROM reader data
- rom_data_valid  input  1  ROM reader data valid (may stay high more than one cycle)

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is synchronous and active-low.
- Reset values: state IDLE; all entries invalid; replacement pointer 0; req_ready=0 during reset; rsp_valid=0; rsp_data=0; rom_addr_valid=0; rom_addr=0; flush_pending=0.
- Reset mid-transaction aborts it. Any later rom_data_valid edge from the aborted read is ignored, because the block is no longer in WAIT.
- Tag: req_addr[ADDR_W-1:2]; each entry holds valid, tag and 32-bit data.
- req_ready = (state==IDLE) && !flush_pending. A request transfers on a clock edge with req_valid && req_ready; req_addr is captured.
- States:
  - IDLE, hit: on accept, go to RESP with rsp_data = entry data and rsp_valid=1 on the next cycle. Hit latency is 1 cycle.
  - IDLE, miss: on accept, go to ISSUE. rom_addr = {tag,2'b00} and rom_addr_valid=1 from the next cycle.
  - ISSUE: hold rom_addr_valid and rom_addr stable until a cycle with rom_addr_ready=1. On that edge, drop rom_addr_valid and go to WAIT.
  - WAIT: detect the rising edge of rom_data_valid (registered previous value 0, current 1); ignore a level already high on entry.
    - On the edge, write {valid=1, tag, rom_data} to entry[ptr] and set ptr = (ptr+1) mod DEPTH.
    - Drive rsp_data = rom_data, rsp_valid=1, and go to RESP.
  - RESP: hold rsp_data/rsp_valid until rsp_ready=1. On that edge, rsp_valid=0 and go to IDLE.
  - Miss latency: accept at cycle N, rom_addr_valid at N+1, rsp_valid 1 cycle after the rom_data_valid edge.
- Lookup compares all valid entries in parallel. At most one entry can match; a fill only occurs after a miss on that tag.
- Flush:
  - When state==IDLE, flush clears all valid bits and ptr on the next edge; it takes priority over a same-cycle request (req_ready is 0 that cycle).
  - Outside IDLE, flush sets flush_pending. The in-flight fill still completes and its response is still returned. Invalidation happens on the first IDLE cycle, then flush_pending clears.
- Replacement is round-robin regardless of the valid bits.
- Address arithmetic is modulo 2^ADDR_W.

Optional Feature:
- Macro: ROM_FETCH_PREFETCH_EN.
- Defined:
  - After RESP completes for a miss, if (missaddr+4) mod 2^ADDR_W is not buffered, enter PF_ISSUE/PF_WAIT. These behave as ISSUE/WAIT but fill without responding. req_ready=0 during prefetch.
  - A request held during prefetch is accepted on return to IDLE and hits if it matched.
  - A flush during prefetch discards the prefetch fill.
- Undefined: no prefetch logic; states PF_* are absent.

Test Plan:
- Reset, then req 0x000100 -> rom_addr_valid=1 with rom_addr=0x000100 the next cycle. Model returns 0x01234567 -> rsp_valid=1, rsp_data=0x01234567.
- Repeat req 0x000102 (same word) -> rsp_valid exactly 1 cycle after accept, data 0x01234567, no rom_addr_valid.
- Misses to 0x10,0x20,0x30,0x40,0x50 with DEPTH=4 -> then 0x10 misses (evicted by 0x50) and 0x20 hits.
- rom_addr_ready held 0 for 10 cycles -> rom_addr_valid and rom_addr stable throughout. rsp_ready held 0 for 5 cycles -> rsp_data stable, req_ready=0.
- Flush asserted during WAIT for 0x200 -> response still returned. A subsequent req 0x200 misses (ROM re-read).
- With ROM_FETCH_PREFETCH_EN: miss 0xFFFFFC -> prefetch rom_addr=0x000000 issued after the response. A later req 0x000000 hits in 1 cycle.
